// File: rtl/bcd_result_converter.sv
// Sequential binary-to-BCD converter for the lab ALU result.
// Captures a WIDTH-bit result (unsigned or two's complement), converts its
// magnitude by shift-and-add-3, one bit per clock, and presents the packed
// digits, a sign flag and a leading-zero blanking mask to the display driver.
module bcd_result_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  input  logic                  in_signed,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] scratch_q, scratch_d;
  logic [WIDTH-1:0]    mag_q, mag_d;
  logic                sign_q, sign_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                neg_q, neg_d;
  logic [DIGITS-1:0]   digit_en_q, digit_en_d;

  // Add 3 to every nibble that is 5 or more, so the following shift carries
  // correctly into the next decimal digit.
  function automatic logic [4*DIGITS-1:0] adjust(input logic [4*DIGITS-1:0] scr);
    logic [4*DIGITS-1:0] r;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = (scr[4*i +: 4] >= 4'd5) ? (scr[4*i +: 4] + 4'd3) : scr[4*i +: 4];
    end
    return r;
  endfunction

  // Digit i is enabled when it or any more significant digit is nonzero;
  // the units digit is always enabled so a zero result still shows "0".
  function automatic logic [DIGITS-1:0] lead_mask(input logic [4*DIGITS-1:0] d);
    logic [DIGITS-1:0] m;
    logic              seen;
    seen = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen = seen | (d[4*i +: 4] != 4'd0);
      m[i] = seen;
    end
    m[0] = 1'b1;
    return m;
  endfunction

  // Next-state and next-output computation for the IDLE/SHIFT sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    scratch_d  = scratch_q;
    mag_d      = mag_q;
    sign_d     = sign_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    neg_d      = neg_q;
    digit_en_d = digit_en_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Negative zero cannot occur: value 0 has a clear sign bit.
          sign_d    = in_signed & value[WIDTH-1];
          mag_d     = (in_signed && value[WIDTH-1]) ? (~value + WIDTH'(1)) : value;
          scratch_d = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = S_SHIFT;
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        {scratch_d, mag_d} = {adjust(scratch_q), mag_q} << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          bcd_d      = scratch_d;
          neg_d      = sign_q;
          digit_en_d = lead_mask(scratch_d);
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end else begin
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any conversion immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      scratch_q  <= '0;
      mag_q      <= '0;
      sign_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      neg_q      <= 1'b0;
      digit_en_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      scratch_q  <= scratch_d;
      mag_q      <= mag_d;
      sign_q     <= sign_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      neg_q      <= neg_d;
      digit_en_q <= digit_en_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign neg      = neg_q;
  assign digit_en = digit_en_q;

endmodule

// File: tb/tb_bcd_result_converter.sv
// Self-checking bench for bcd_result_converter: directed cases plus random
// values compared against a decimal-arithmetic reference model.
module tb_bcd_result_converter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] value;
  logic        in_signed;
  logic        busy;
  logic        done;
  logic [19:0] bcd;
  logic        neg;
  logic [4:0]  digit_en;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  bcd_result_converter #(.WIDTH(16), .DIGITS(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .value     (value),
    .in_signed (in_signed),
    .busy      (busy),
    .done      (done),
    .bcd       (bcd),
    .neg       (neg),
    .digit_en  (digit_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: signed magnitude by plain arithmetic, digits by /10 and %10.
  task automatic ref_conv(input logic [15:0] v, input logic s,
                          output logic [19:0] b, output logic n, output logic [4:0] en);
    int m;
    int hi;
    int d;
    n  = s && v[15];
    m  = n ? (65536 - int'({16'd0, v})) : int'({16'd0, v});
    b  = 20'd0;
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      d = m % 10;
      b[4*i +: 4] = 4'(d);
      if (d != 0) hi = i;
      m = m / 10;
    end
    en = 5'((1 << (hi + 1)) - 1);
  endtask

  // One conversion from IDLE; optional extra start pulse before SHIFT edge pulse_at.
  task automatic conv(input string tag, input logic [15:0] v, input logic s, input int pulse_at,
                      input logic [19:0] eb, input logic eneg, input logic [4:0] een);
    start = 1'b1; value = v; in_signed = s;
    @(posedge clk); #1;
    start = 1'b0; value = 16'($urandom); in_signed = ~s;
    check({tag, "_busy_e0"}, 32'(busy), 32'd1);
    check({tag, "_done_e0"}, 32'(done), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      if (i == pulse_at) begin
        start = 1'b1; value = 16'h0001;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (i < 16) begin
        if (busy !== 1'b1 || done !== 1'b0)
          check({tag, "_busy_mid"}, {30'd0, busy, done}, 32'd2);
      end else begin
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_bcd"}, 32'(bcd), 32'(eb));
        check({tag, "_neg"}, 32'(neg), 32'(eneg));
        check({tag, "_en"}, 32'(digit_en), 32'(een));
      end
    end
    start = 1'b0;
  endtask

  initial begin
    logic [19:0] eb;
    logic        en_n;
    logic [4:0]  een;
    int          done_seen;

    rst = 1'b1; start = 1'b0; value = 16'd0; in_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_neg", 32'(neg), 32'd0);
    check("rst_en", 32'(digit_en), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases with hand-computed results.
    conv("fe",      16'h00FE, 1'b0, 0, 20'h00254, 1'b0, 5'b00111);
    conv("ffff_s",  16'hFFFF, 1'b1, 0, 20'h00001, 1'b1, 5'b00001);
    conv("ffff_u",  16'hFFFF, 1'b0, 0, 20'h65535, 1'b0, 5'b11111);
    conv("8000_s",  16'h8000, 1'b1, 0, 20'h32768, 1'b1, 5'b11111);
    conv("zero_s",  16'h0000, 1'b1, 0, 20'h00000, 1'b0, 5'b00001);

    // Start pulse during SHIFT is ignored; outputs hold afterwards.
    conv("ign", 16'h007F, 1'b0, 5, 20'h00127, 1'b0, 5'b00111);
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
    end
    check("ign_no_extra_done", 32'(done_seen), 32'd0);
    check("ign_hold_bcd", 32'(bcd), 32'h00127);
    check("ign_idle", 32'(busy), 32'd0);

    // Start held high: done every 17 cycles.
    start = 1'b1; value = 16'h0064; in_signed = 1'b0;
    for (int c = 0; c <= 52; c++) begin
      @(posedge clk); #1;
      check($sformatf("held_done_c%0d", c), 32'(done), 32'(c == 16 || c == 33 || c == 50));
      if (done === 1'b1) begin
        check("held_bcd", 32'(bcd), 32'h00100);
        check("held_en", 32'(digit_en), 32'h07);
      end
    end
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of SHIFT.
    start = 1'b1; value = 16'h1234; in_signed = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bcd", 32'(bcd), 32'd0);
    check("abort_neg", 32'(neg), 32'd0);
    check("abort_en", 32'(digit_en), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    conv("1234", 16'h1234, 1'b0, 0, 20'h04660, 1'b0, 5'b01111);

    // Random values against the reference model.
    for (int k = 0; k < 16; k++) begin
      logic [15:0] rv;
      logic        rs;
      rv = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      ref_conv(rv, rs, eb, en_n, een);
      conv($sformatf("rnd%0d_%h_%0d", k, rv, rs), rv, rs, 0, eb, en_n, een);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
